// File: rtl/texture_pkg.sv
// -----------------------------------------------------------------------------
// texture_pkg
// Shared definitions for the texture fetch responder:
//   - tex_state_t      : responder FSM states
//   - request fields   : core_id and texel index positions in a FIFO_TEXTURE word
//   - rsp_word_t       : order of the two words pushed into FIFO_RGB per request
//   - NUM_CORES        : number of render cores sharing the texture path
//   - texel_byte_addr  : texel index -> byte address in the texture buffer
//   - id_word          : core_id -> zero-extended FIFO_RGB word
// -----------------------------------------------------------------------------
package texture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_PUSH_DATA = 3'd3,
        ST_PUSH_ID   = 3'd4
    } tex_state_t;

    localparam int CORE_ID_MSB = 30;
    localparam int CORE_ID_LSB = 24;
    localparam int CORE_ID_W   = CORE_ID_MSB - CORE_ID_LSB + 1;
    localparam int IDX_W       = 24;

    // The texture arbiter consumes the texel first and the core ID second.
    typedef enum logic {
        RSP_WORD_DATA = 1'b0,
        RSP_WORD_ID   = 1'b1
    } rsp_word_t;

    // core_id values at or above this count are passed through unchecked.
    localparam int NUM_CORES = 87;

    // Texels are 32-bit, so the index is scaled by 4; the add wraps at 32 bits.
    function automatic logic [31:0] texel_byte_addr(input logic [31:0]      base,
                                                    input logic [IDX_W-1:0] idx);
        return base + {{(32 - IDX_W - 2){1'b0}}, idx, 2'b00};
    endfunction

    function automatic logic [31:0] id_word(input logic [CORE_ID_W-1:0] core_id);
        return {{(32 - CORE_ID_W){1'b0}}, core_id};
    endfunction

endpackage

// File: rtl/tex_last_texel_cache.sv
// -----------------------------------------------------------------------------
// tex_last_texel_cache
// Single-entry cache holding the most recently fetched texel.
// Ports:
//   clk, rst_n              : clock, async active-low reset (entry invalid)
//   lookup_tag              : texel index being requested
//   lookup_hit, lookup_data : hit flag (combinational) and cached texel
//   fill_en, fill_tag,
//   fill_data               : write a fetched texel into the entry
//   flush                   : invalidate the entry; also suppresses a same-cycle
//                             hit and wins over a same-cycle fill
// Parameter CACHE_EN = 0 keeps the entry permanently invalid.
// -----------------------------------------------------------------------------
module tex_last_texel_cache
    import texture_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] lookup_tag,
    output logic             lookup_hit,
    output logic [31:0]      lookup_data,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_tag,
    input  logic [31:0]      fill_data,
    input  logic             flush
);

    logic             valid_q, valid_d;
    logic [IDX_W-1:0] tag_q, tag_d;
    logic [31:0]      data_q, data_d;

    // A flush in the same cycle as a lookup must not hit: the buffer is being
    // rewritten, so the cached value can no longer be trusted.
    assign lookup_hit  = CACHE_EN && valid_q && (tag_q == lookup_tag) && !flush;
    assign lookup_data = data_q;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            data_d  = fill_data;
        end
        // Flush is applied after the fill so it wins when both coincide.
        if (flush) begin
            valid_d = 1'b0;
        end
        if (!CACHE_EN) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/texture_fetch_responder.sv
// -----------------------------------------------------------------------------
// texture_fetch_responder
// Pops {core_id, texel index} requests from FIFO_TEXTURE, fetches the texel
// over an Avalon-MM read master (or from the last-texel cache) and pushes the
// response into FIFO_RGB as two adjacent words: texel, then core ID.
// Parameters:
//   TEX_BASE : byte base address of the texture buffer
//   CACHE_EN : 1 enables the last-texel cache
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   FF_texture_empty/_readrequest/_q: show-ahead request FIFO
//   FF_rgb_almostfull/_writerequest/
//   FF_rgb_data                     : response FIFO (almostfull leaves >= 2 slots)
//   avm_address/_read/_waitrequest/
//   avm_readdata/_readdatavalid     : Avalon-MM read master, one read in flight
//   cache_flush                     : invalidate cached texel
//   busy                            : FSM not idle
//   stat_req_count, stat_hit_count  : wrapping request / cache-hit counters
// -----------------------------------------------------------------------------
module texture_fetch_responder
    import texture_pkg::*;
#(
    parameter logic [31:0] TEX_BASE = 32'h0000_0000,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        FF_texture_empty,
    output logic        FF_texture_readrequest,
    input  logic [31:0] FF_texture_q,
    input  logic        FF_rgb_almostfull,
    output logic        FF_rgb_writerequest,
    output logic [31:0] FF_rgb_data,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic        cache_flush,
    output logic        busy,
    output logic [31:0] stat_req_count,
    output logic [31:0] stat_hit_count
);

    tex_state_t           state_q, state_d;
    logic [CORE_ID_W-1:0] core_id_q, core_id_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [31:0]          texel_q, texel_d;
    logic [31:0]          req_count_q, req_count_d;
    logic [31:0]          hit_count_q, hit_count_d;

    logic                 cache_hit;
    logic [31:0]          cache_data;
    logic                 cache_fill;

    // Bit 31 of the request word carries no meaning for this block.
    logic                 unused_req_msb;
    assign unused_req_msb = FF_texture_q[31];

    tex_last_texel_cache #(
        .CACHE_EN (CACHE_EN)
    ) u_cache (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_tag  (FF_texture_q[IDX_W-1:0]),
        .lookup_hit  (cache_hit),
        .lookup_data (cache_data),
        .fill_en     (cache_fill),
        .fill_tag    (idx_q),
        .fill_data   (avm_readdata),
        .flush       (cache_flush)
    );

    always_comb begin
        state_d                = state_q;
        core_id_d              = core_id_q;
        idx_d                  = idx_q;
        texel_d                = texel_q;
        req_count_d            = req_count_q;
        hit_count_d            = hit_count_q;
        FF_texture_readrequest = 1'b0;
        FF_rgb_writerequest    = 1'b0;
        FF_rgb_data            = '0;
        avm_read               = 1'b0;
        avm_address            = '0;
        cache_fill             = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The pop is combinational; gating with rst_n keeps it low
                // while the block is held in reset.
                if (!FF_texture_empty && rst_n) begin
                    FF_texture_readrequest = 1'b1;
                    core_id_d   = FF_texture_q[CORE_ID_MSB:CORE_ID_LSB];
                    idx_d       = FF_texture_q[IDX_W-1:0];
                    req_count_d = req_count_q + 32'd1;
                    if (cache_hit) begin
                        texel_d     = cache_data;
                        hit_count_d = hit_count_q + 32'd1;
                        state_d     = ST_PUSH_DATA;
                    end else begin
                        state_d     = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                avm_read    = 1'b1;
                avm_address = texel_byte_addr(TEX_BASE, idx_q);
                if (!avm_waitrequest) begin
                    state_d = ST_WAIT_DATA;
                end
            end

            ST_WAIT_DATA: begin
                if (avm_readdatavalid) begin
                    texel_d    = avm_readdata;
                    cache_fill = 1'b1;
                    state_d    = ST_PUSH_DATA;
                end
            end

            ST_PUSH_DATA: begin
                if (!FF_rgb_almostfull) begin
                    FF_rgb_writerequest = 1'b1;
                    FF_rgb_data         = texel_q;
                    state_d             = ST_PUSH_ID;
                end
            end

            ST_PUSH_ID: begin
                // The almostfull threshold reserves room for this second word,
                // so the pair is never split.
                FF_rgb_writerequest = 1'b1;
                FF_rgb_data         = id_word(core_id_q);
                state_d             = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            core_id_q   <= '0;
            idx_q       <= '0;
            texel_q     <= '0;
            req_count_q <= '0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            core_id_q   <= core_id_d;
            idx_q       <= idx_d;
            texel_q     <= texel_d;
            req_count_q <= req_count_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign stat_req_count = req_count_q;
    assign stat_hit_count = hit_count_q;

endmodule

// File: tb/tb_texture_fetch_responder.sv
module tb_texture_fetch_responder;

   localparam logic [31:0] TEX_BASE = 32'hFE00_0000;
   localparam bit          CACHE_EN = 1'b1;

   typedef struct {
      logic [31:0] word;
      bit          isId;
   } expWord_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ffTextureEmpty;
   logic        ffTextureReadrequest;
   logic [31:0] ffTextureQ;
   logic        ffRgbAlmostfull;
   logic        ffRgbWriterequest;
   logic [31:0] ffRgbData;
   logic [31:0] avmAddress;
   logic        avmRead;
   logic        avmWaitrequest;
   logic [31:0] avmReaddata;
   logic        avmReaddatavalid;
   logic        cacheFlush;
   logic        dutBusy;
   logic [31:0] statReqCount;
   logic [31:0] statHitCount;

   int testsRun = 0;
   int testsFailed = 0;
   int cyc = 0;

   // Environment state: request FIFO contents, memory image, slave and knobs
   logic [31:0] reqQ[$];
   logic [31:0] memory [logic [31:0]];
   int unsigned waitPct = 0, fullPct = 0, spuriousPct = 0, flushPct = 0;
   int          waitHold = 0, fullHold = 0, flushAtCycle = -1, readLatency = 1;
   bit          randomLatency = 1'b0;
   bit          slavePending = 1'b0;
   int          slaveDue = 0;
   logic [31:0] slaveData = '0;
   bit          deliverNow = 1'b0;

   // Reference model: outstanding request, last-texel cache, expected words
   expWord_t    expWords[$];
   bit          missPending = 1'b0, missAccepted = 1'b0;
   logic [23:0] missIdx = '0;
   logic [6:0]  missCore = '0;
   bit          mCacheValid = 1'b0;
   logic [23:0] mCacheTag = '0;
   logic [31:0] mCacheData = '0;
   int          modelReqCount = 0, modelHitCount = 0;
   int          idDueCycle = -10;

   // Per-test logs used by the directed timing checks
   logic [31:0] capturedWords[$];
   int          writeCycles[$], popCycles[$], acceptCycles[$], rdvCycles[$];
   int          readHighCycles = 0, readsAccepted = 0;

   texture_fetch_responder #(
      .TEX_BASE (TEX_BASE),
      .CACHE_EN (CACHE_EN)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .FF_texture_empty       (ffTextureEmpty),
      .FF_texture_readrequest (ffTextureReadrequest),
      .FF_texture_q           (ffTextureQ),
      .FF_rgb_almostfull      (ffRgbAlmostfull),
      .FF_rgb_writerequest    (ffRgbWriterequest),
      .FF_rgb_data            (ffRgbData),
      .avm_address            (avmAddress),
      .avm_read               (avmRead),
      .avm_waitrequest        (avmWaitrequest),
      .avm_readdata           (avmReaddata),
      .avm_readdatavalid      (avmReaddatavalid),
      .cache_flush            (cacheFlush),
      .busy                   (dutBusy),
      .stat_req_count         (statReqCount),
      .stat_hit_count         (statHitCount)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Hard time limit so a stuck design can never hang the run
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it, and reports and counts a failure
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Memory contents: explicit entries, otherwise an address-derived pattern
   function automatic logic [31:0] memRead(input logic [31:0] addr);
      if (memory.exists(addr)) return memory[addr];
      return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] byteAddr(input logic [23:0] idx);
      return TEX_BASE + (32'(idx) << 2);
   endfunction

   // Queue one request word into FIFO_TEXTURE (bit 31 is random noise)
   task automatic applyStimulus(input logic [6:0] core, input logic [23:0] idx);
      logic noise;
      noise = 1'($urandom_range(1));
      reqQ.push_back({noise, core, idx});
   endtask

   task automatic clearLog();
      capturedWords.delete();
      writeCycles.delete();
      popCycles.delete();
      acceptCycles.delete();
      rdvCycles.delete();
      readHighCycles = 0;
      readsAccepted = 0;
   endtask

   // Reference model reaction to one sampled cycle, plus the per-cycle checks
   task automatic sampleCycle();
      logic [31:0] req;
      expWord_t    e;
      int          lat;

      if (ffTextureReadrequest) begin
         checkOutput("pop_not_empty", 32'(ffTextureEmpty), 32'd0);
         if (reqQ.size() > 0) begin
            req = reqQ.pop_front();
            popCycles.push_back(cyc);
            modelReqCount++;
            if (CACHE_EN && mCacheValid && mCacheTag == req[23:0] && !cacheFlush) begin
               modelHitCount++;
               expWords.push_back('{mCacheData, 1'b0});
               expWords.push_back('{{25'd0, req[30:24]}, 1'b1});
            end else begin
               missPending = 1'b1;
               missAccepted = 1'b0;
               missIdx = req[23:0];
               missCore = req[30:24];
            end
         end
      end

      if (avmRead) begin
         readHighCycles++;
         checkOutput("read_expected", 32'(missPending && !missAccepted), 32'd1);
         checkOutput("avm_address", avmAddress, byteAddr(missIdx));
         if (avmWaitrequest) begin
            if (waitHold > 0) waitHold--;
         end else begin
            checkOutput("one_outstanding", 32'(slavePending), 32'd0);
            lat = randomLatency ? int'($urandom_range(4, 1)) : readLatency;
            slavePending = 1'b1;
            slaveDue = cyc + lat;
            slaveData = memRead(avmAddress);
            missAccepted = 1'b1;
            readsAccepted++;
            acceptCycles.push_back(cyc);
         end
      end

      if (deliverNow && missPending && missAccepted) begin
         expWords.push_back('{avmReaddata, 1'b0});
         expWords.push_back('{{25'd0, missCore}, 1'b1});
         if (!cacheFlush) begin
            mCacheValid = 1'b1;
            mCacheTag = missIdx;
            mCacheData = avmReaddata;
         end
         missPending = 1'b0;
         rdvCycles.push_back(cyc);
      end
      if (cacheFlush) mCacheValid = 1'b0;

      if (cyc == idDueCycle) begin
         checkOutput("id_adjacent", 32'(ffRgbWriterequest), 32'd1);
      end
      if (ffRgbWriterequest) begin
         capturedWords.push_back(ffRgbData);
         writeCycles.push_back(cyc);
         checkOutput("rgb_write_expected", 32'(expWords.size() > 0), 32'd1);
         if (expWords.size() > 0) begin
            e = expWords.pop_front();
            if (e.isId) begin
               checkOutput("rgb_id_word", ffRgbData, e.word);
            end else begin
               checkOutput("rgb_data_word", ffRgbData, e.word);
               checkOutput("data_while_full", 32'(ffRgbAlmostfull), 32'd0);
               idDueCycle = cyc + 1;
            end
         end
      end
   endtask

   // Drive inputs just after the falling edge, then sample settled outputs
   task automatic stepCycle();
      @(negedge clk);
      cyc++;
      ffTextureEmpty = (reqQ.size() == 0);
      ffTextureQ = ffTextureEmpty ? $urandom() : reqQ[0];
      avmWaitrequest = (waitHold > 0) || ($urandom_range(99) < waitPct);
      ffRgbAlmostfull = (fullHold > 0) || ($urandom_range(99) < fullPct);
      if (fullHold > 0) fullHold--;
      cacheFlush = (cyc == flushAtCycle) || ($urandom_range(99) < flushPct);
      // A flush stands for a rewrite of the buffer, so change the cached texel
      if (cacheFlush && mCacheValid) memory[byteAddr(mCacheTag)] = $urandom();
      deliverNow = slavePending && (cyc == slaveDue);
      if (deliverNow) begin
         avmReaddatavalid = 1'b1;
         avmReaddata = slaveData;
         slavePending = 1'b0;
      end else begin
         avmReaddatavalid = !slavePending && ($urandom_range(99) < spuriousPct);
         avmReaddata = $urandom();
      end
      #1;
      sampleCycle();
   endtask

   // Run until all queued work has come out, within a cycle budget
   task automatic waitDrain(input int maxCycles);
      int n;
      n = 0;
      while ((reqQ.size() != 0 || missPending || expWords.size() != 0 || dutBusy) && n < maxCycles) begin
         stepCycle();
         n++;
      end
      checkOutput("drain_in_time", 32'(n < maxCycles), 32'd1);
   endtask

   // Reset-value check on all outputs
   task automatic checkResetOutputs(input string phase);
      checkOutput({phase, "_readrequest"}, 32'(ffTextureReadrequest), 32'd0);
      checkOutput({phase, "_writerequest"}, 32'(ffRgbWriterequest), 32'd0);
      checkOutput({phase, "_rgb_data"}, ffRgbData, 32'd0);
      checkOutput({phase, "_avm_read"}, 32'(avmRead), 32'd0);
      checkOutput({phase, "_avm_address"}, avmAddress, 32'd0);
      checkOutput({phase, "_busy"}, 32'(dutBusy), 32'd0);
      checkOutput({phase, "_req_count"}, statReqCount, 32'd0);
      checkOutput({phase, "_hit_count"}, statHitCount, 32'd0);
   endtask

   // Directed scenarios followed by a randomized soak
   initial begin
      rst_n = 1'b0;
      ffTextureEmpty = 1'b1;
      ffTextureQ = '0;
      ffRgbAlmostfull = 1'b0;
      avmWaitrequest = 1'b0;
      avmReaddata = '0;
      avmReaddatavalid = 1'b0;
      cacheFlush = 1'b0;

      repeat (3) stepCycle();
      checkResetOutputs("reset");
      rst_n = 1'b1;
      stepCycle();

      // Miss, then identical request (hit), then a different index (miss)
      clearLog();
      memory[TEX_BASE + 32'h40] = 32'hAABB_CCDD;
      applyStimulus(7'h05, 24'h00_0010);
      applyStimulus(7'h05, 24'h00_0010);
      applyStimulus(7'h06, 24'h00_0011);
      waitDrain(100);
      checkOutput("t1_pops", 32'(popCycles.size()), 32'd3);
      checkOutput("t1_writes", 32'(writeCycles.size()), 32'd6);
      if (popCycles.size() == 3 && writeCycles.size() == 6 && acceptCycles.size() > 0 && rdvCycles.size() > 0) begin
         checkOutput("t1_word0", capturedWords[0], 32'hAABB_CCDD);
         checkOutput("t1_word1", capturedWords[1], 32'h0000_0005);
         checkOutput("t1_word2", capturedWords[2], 32'hAABB_CCDD);
         checkOutput("t1_word3", capturedWords[3], 32'h0000_0005);
         checkOutput("t1_read_lat", 32'(acceptCycles[0] - popCycles[0]), 32'd1);
         checkOutput("t1_rdv_lat", 32'(rdvCycles[0] - popCycles[0]), 32'd2);
         checkOutput("t1_data_lat", 32'(writeCycles[0] - popCycles[0]), 32'd3);
         checkOutput("t1_id_lat", 32'(writeCycles[1] - popCycles[0]), 32'd4);
         checkOutput("t1_next_pop", 32'(popCycles[1] - popCycles[0]), 32'd5);
         checkOutput("t2_hit_data_lat", 32'(writeCycles[2] - popCycles[1]), 32'd1);
         checkOutput("t2_hit_id_lat", 32'(writeCycles[3] - popCycles[1]), 32'd2);
         checkOutput("t2_next_pop", 32'(popCycles[2] - popCycles[1]), 32'd3);
      end
      checkOutput("t2_reads", 32'(readsAccepted), 32'd2);
      checkOutput("t2_req_count", statReqCount, 32'd3);
      checkOutput("t2_hit_count", statHitCount, 32'd1);

      // Three cycles of waitrequest stall
      clearLog();
      waitHold = 3;
      applyStimulus(7'h10, 24'h00_0123);
      waitDrain(100);
      checkOutput("t3_read_cycles", 32'(readHighCycles), 32'd4);
      checkOutput("t3_reads", 32'(readsAccepted), 32'd1);
      checkOutput("t3_writes", 32'(writeCycles.size()), 32'd2);
      if (acceptCycles.size() == 1 && popCycles.size() == 1) begin
         checkOutput("t3_accept_lat", 32'(acceptCycles[0] - popCycles[0]), 32'd4);
      end

      // Five cycles of almostfull while the hit sits in the data-push state
      clearLog();
      fullHold = 6;
      applyStimulus(7'h11, 24'h00_0123);
      waitDrain(100);
      checkOutput("t4_reads", 32'(readsAccepted), 32'd0);
      checkOutput("t4_hit_count", statHitCount, 32'd2);
      checkOutput("t4_writes", 32'(writeCycles.size()), 32'd2);
      if (writeCycles.size() == 2 && popCycles.size() == 1) begin
         checkOutput("t4_data_lat", 32'(writeCycles[0] - popCycles[0]), 32'd6);
         checkOutput("t4_id_lat", 32'(writeCycles[1] - popCycles[0]), 32'd7);
         checkOutput("t4_id_word", capturedWords[1], 32'h0000_0011);
      end

      // Flush in the fill cycle: the same index must be fetched again
      clearLog();
      applyStimulus(7'h22, 24'h00_0200);
      flushAtCycle = cyc + 3;
      waitDrain(100);
      if (rdvCycles.size() == 1) begin
         checkOutput("t5_flush_on_fill", 32'(rdvCycles[0]), 32'(flushAtCycle));
      end
      flushAtCycle = -1;
      applyStimulus(7'h22, 24'h00_0200);
      waitDrain(100);
      checkOutput("t5_reads", 32'(readsAccepted), 32'd2);
      checkOutput("t5_hit_count", statHitCount, 32'd2);

      // Reset while waiting for data; the late readdatavalid must be ignored
      clearLog();
      readLatency = 4;
      applyStimulus(7'h33, 24'h00_0300);
      repeat (3) stepCycle();
      checkOutput("t6_in_wait", 32'(acceptCycles.size()), 32'd1);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("t6_async_reset");
      missPending = 1'b0;
      expWords.delete();
      mCacheValid = 1'b0;
      modelReqCount = 0;
      modelHitCount = 0;
      idDueCycle = -10;
      stepCycle();
      rst_n = 1'b1;
      repeat (5) stepCycle();
      checkOutput("t6_no_writes", 32'(capturedWords.size()), 32'd0);
      checkOutput("t6_idle", 32'(dutBusy), 32'd0);
      readLatency = 1;
      clearLog();
      applyStimulus(7'h44, 24'h00_0200);
      waitDrain(100);
      checkOutput("t6_reads", 32'(readsAccepted), 32'd1);
      checkOutput("t6_writes", 32'(capturedWords.size()), 32'd2);
      checkOutput("t6_req_count", statReqCount, 32'd1);
      checkOutput("t6_hit_count", statHitCount, 32'd0);

      // Randomized soak against the reference model
      waitPct = 25;
      fullPct = 25;
      spuriousPct = 10;
      flushPct = 4;
      randomLatency = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if (reqQ.size() < 2 && $urandom_range(99) < 40) begin
            if ($urandom_range(5) == 0) applyStimulus(7'($urandom_range(127)), 24'hFF_FFFF);
            else applyStimulus(7'($urandom_range(127)), 24'(32'h100 + $urandom_range(4)));
         end
         stepCycle();
      end
      waitPct = 0;
      fullPct = 0;
      spuriousPct = 0;
      flushPct = 0;
      waitDrain(500);
      checkOutput("rand_req_count", statReqCount, 32'(modelReqCount));
      checkOutput("rand_hit_count", statHitCount, 32'(modelHitCount));
      checkOutput("rand_idle", 32'(dutBusy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
